// File: rtl/dp_draw_unit_pkg.sv
// rtl/dp_draw_unit_pkg.sv - shared constants, field positions and state type for the draw datapath
package dp_draw_unit_pkg;

    localparam int INSTRUCTION_WIDTH = 40;
    localparam int RESULT_WIDTH      = 32;
    localparam int X_COORD_WIDTH     = 8;
    localparam int Y_COORD_WIDTH     = 7;
    localparam int COLOUR_WIDTH      = 3;
    localparam int OPCODE_WIDTH      = 4;
    // 160x120 pixels fit in 15 bits; one spare bit keeps the walker simple.
    localparam int COUNT_WIDTH       = 16;

    localparam logic [OPCODE_WIDTH-1:0] OPCODE_DRAW = 4'h1;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_FILL = 4'h2;
    localparam logic [COLOUR_WIDTH-1:0] COLOUR_BG   = 3'b000;

    // Instruction field LSB positions.
    localparam int OPCODE_LSB    = 0;
    localparam int DRAW_X_LSB    = 4;
    localparam int DRAW_Y_LSB    = 12;
    localparam int DRAW_C_LSB    = 19;
    localparam int DRAW_PLOT_BIT = 22;
    localparam int FILL_X0_LSB   = 4;
    localparam int FILL_Y0_LSB   = 12;
    localparam int FILL_X1_LSB   = 19;
    localparam int FILL_Y1_LSB   = 27;
    localparam int FILL_C_LSB    = 34;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_PLOT,
        ST_GAP,
        ST_DONE
    } dp_state_t;

    function automatic logic [X_COORD_WIDTH-1:0] clip_x(input logic [X_COORD_WIDTH-1:0] v,
                                                       input logic [X_COORD_WIDTH-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [Y_COORD_WIDTH-1:0] clip_y(input logic [Y_COORD_WIDTH-1:0] v,
                                                       input logic [Y_COORD_WIDTH-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/dp_draw_unit_raster_walker.sv
// rtl/dp_draw_unit_raster_walker.sv - raster-order pixel walker with pixel counter
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   init                  load start corner, bounds, clear count
//   init_x0/y0/x1/y1      rectangle corners (already clipped, non-empty)
//   step                  current pixel written: count it and advance
//   cur_x, cur_y          current pixel
//   count                 pixels written since init
//   last                  current pixel is the final corner (x1,y1)
module dp_raster_walker
    import dp_draw_unit_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     init,
    input  logic [X_COORD_WIDTH-1:0] init_x0,
    input  logic [Y_COORD_WIDTH-1:0] init_y0,
    input  logic [X_COORD_WIDTH-1:0] init_x1,
    input  logic [Y_COORD_WIDTH-1:0] init_y1,
    input  logic                     step,
    output logic [X_COORD_WIDTH-1:0] cur_x,
    output logic [Y_COORD_WIDTH-1:0] cur_y,
    output logic [COUNT_WIDTH-1:0]   count,
    output logic                     last
);

    localparam logic [X_COORD_WIDTH-1:0] X_ONE = 1;
    localparam logic [Y_COORD_WIDTH-1:0] Y_ONE = 1;
    localparam logic [COUNT_WIDTH-1:0]   C_ONE = 1;

    logic [X_COORD_WIDTH-1:0] x0_q;
    logic [X_COORD_WIDTH-1:0] x1_q;
    logic [Y_COORD_WIDTH-1:0] y1_q;

    assign last = (cur_x == x1_q) && (cur_y == y1_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_x <= '0;
            cur_y <= '0;
            count <= '0;
            x0_q  <= '0;
            x1_q  <= '0;
            y1_q  <= '0;
        end else if (init) begin
            cur_x <= init_x0;
            cur_y <= init_y0;
            count <= '0;
            x0_q  <= init_x0;
            x1_q  <= init_x1;
            y1_q  <= init_y1;
        end else if (step) begin
            count <= count + C_ONE;
            // Park on the final pixel so the port keeps showing it until DONE.
            if (!last) begin
                if (cur_x == x1_q) begin
                    cur_x <= x0_q;
                    cur_y <= cur_y + Y_ONE;
                end else begin
                    cur_x <= cur_x + X_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/dp_draw_unit.sv
// rtl/dp_draw_unit.sv - instruction decode and DRAW/FILL execution onto the VGA write port
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   start_dp          instruction strobe (accepted on its rising edge only)
//   instruction_dp    instruction word, stable while start_dp is high
//   finished_dp       high when idle or done, low while executing
//   result_dp         result of the last completed instruction
//   vga_x/y/colour    pixel being written
//   vga_plot          VGA adapter write enable
module dp_draw_unit
    import dp_draw_unit_pkg::*;
#(
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120,
    parameter int WRITE_HOLD = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start_dp,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_dp,
    output logic                         finished_dp,
    output logic [RESULT_WIDTH-1:0]      result_dp,
    output logic [X_COORD_WIDTH-1:0]     vga_x,
    output logic [Y_COORD_WIDTH-1:0]     vga_y,
    output logic [COLOUR_WIDTH-1:0]      vga_colour,
    output logic                         vga_plot
);

    localparam logic [X_COORD_WIDTH-1:0] X_MAX     = X_COORD_WIDTH'(SCREEN_W - 1);
    localparam logic [Y_COORD_WIDTH-1:0] Y_MAX     = Y_COORD_WIDTH'(SCREEN_H - 1);
    localparam logic [1:0]               HOLD_LAST = 2'(WRITE_HOLD - 1);

    dp_state_t state, state_n;

    logic                         start_q;
    logic [INSTRUCTION_WIDTH-1:0] instr_q;
    logic [COLOUR_WIDTH-1:0]      colour_q;
    logic                         use_count;
    logic [RESULT_WIDTH-1:0]      early_result;
    logic [1:0]                   hold_cnt;

    logic accept, w_init, w_step, pix_done, w_last;
    logic [X_COORD_WIDTH-1:0] cur_x;
    logic [Y_COORD_WIDTH-1:0] cur_y;
    logic [COUNT_WIDTH-1:0]   count;

    // Decoded view of the latched instruction.
    logic [OPCODE_WIDTH-1:0]  opcode;
    logic                     is_draw, is_fill;
    logic [X_COORD_WIDTH-1:0] d_x, f_x0, f_x1c;
    logic [Y_COORD_WIDTH-1:0] d_y, f_y0, f_y1c;
    logic [COLOUR_WIDTH-1:0]  d_c, f_c;
    logic                     d_plot, d_in_range, f_nonempty;
    logic                     unused_instr_bits;

    assign opcode     = instr_q[OPCODE_LSB +: OPCODE_WIDTH];
    assign is_draw    = (opcode == OPCODE_DRAW);
    assign is_fill    = (opcode == OPCODE_FILL);
    assign d_x        = instr_q[DRAW_X_LSB +: X_COORD_WIDTH];
    assign d_y        = instr_q[DRAW_Y_LSB +: Y_COORD_WIDTH];
    assign d_c        = instr_q[DRAW_C_LSB +: COLOUR_WIDTH];
    assign d_plot     = instr_q[DRAW_PLOT_BIT];
    assign f_x0       = instr_q[FILL_X0_LSB +: X_COORD_WIDTH];
    assign f_y0       = instr_q[FILL_Y0_LSB +: Y_COORD_WIDTH];
    assign f_x1c      = clip_x(instr_q[FILL_X1_LSB +: X_COORD_WIDTH], X_MAX);
    assign f_y1c      = clip_y(instr_q[FILL_Y1_LSB +: Y_COORD_WIDTH], Y_MAX);
    assign f_c        = instr_q[FILL_C_LSB +: COLOUR_WIDTH];
    assign d_in_range = (d_x <= X_MAX) && (d_y <= Y_MAX);
    // x0/y0 are not clipped: an off-screen start corner makes the rectangle empty.
    assign f_nonempty = (f_x0 <= f_x1c) && (f_y0 <= f_y1c);
    assign unused_instr_bits = ^instr_q[INSTRUCTION_WIDTH-1:FILL_C_LSB+COLOUR_WIDTH];

    assign pix_done = (state == ST_PLOT) && (hold_cnt == HOLD_LAST);

    // A DRAW is walked as a 1x1 rectangle.
    dp_raster_walker u_walker (
        .clock   (clock),
        .reset   (reset),
        .init    (w_init),
        .init_x0 (is_fill ? f_x0  : d_x),
        .init_y0 (is_fill ? f_y0  : d_y),
        .init_x1 (is_fill ? f_x1c : d_x),
        .init_y1 (is_fill ? f_y1c : d_y),
        .step    (w_step),
        .cur_x   (cur_x),
        .cur_y   (cur_y),
        .count   (count),
        .last    (w_last)
    );

    assign vga_x      = cur_x;
    assign vga_y      = cur_y;
    assign vga_colour = colour_q;
    assign vga_plot   = (state == ST_PLOT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        w_init  = 1'b0;
        w_step  = 1'b0;
        case (state)
            ST_IDLE: begin
                // Rising edge only, so the held second strobe cycle cannot relaunch.
                if (start_dp && !start_q) begin
                    accept  = 1'b1;
                    state_n = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if ((is_draw && d_plot && d_in_range) || (is_fill && f_nonempty)) begin
                    w_init  = 1'b1;
                    state_n = ST_PLOT;
                end else begin
                    state_n = ST_DONE;
                end
            end
            ST_PLOT: begin
                if (pix_done) begin
                    w_step = 1'b1;
                    if (w_last) begin
                        state_n = ST_DONE;
                    end else if (WRITE_HOLD > 1) begin
                        state_n = ST_GAP;
                    end
                end
            end
            ST_GAP:  state_n = ST_PLOT;
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            start_q      <= 1'b0;
            instr_q      <= '0;
            colour_q     <= '0;
            use_count    <= 1'b0;
            early_result <= '0;
            hold_cnt     <= '0;
            finished_dp  <= 1'b1;
            result_dp    <= '0;
        end else begin
            start_q <= start_dp;
            if (accept) begin
                instr_q     <= instruction_dp;
                finished_dp <= 1'b0;
            end
            if (state == ST_DECODE) begin
                use_count    <= w_init;
                early_result <= (is_draw || is_fill) ? '0 : '1;
                colour_q     <= is_fill ? f_c : d_c;
            end
            if (state == ST_DONE) begin
                finished_dp <= 1'b1;
                result_dp   <= use_count ? {{(RESULT_WIDTH-COUNT_WIDTH){1'b0}}, count} : early_result;
            end
            if ((state != ST_PLOT) || pix_done) begin
                hold_cnt <= '0;
            end else begin
                hold_cnt <= hold_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_dp_draw_unit.sv
// tb/tb_dp_draw_unit.sv - self-checking bench for dp_draw_unit
module tb_dp_draw_unit;
    import dp_draw_unit_pkg::*;

    localparam int SW    = 160;
    localparam int SH    = 120;
    localparam int WH    = 1;
    localparam int LIMIT = 30000;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_dp;
    logic [39:0] instruction_dp;
    logic        finished_dp;
    logic [31:0] result_dp;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    int tests = 0;
    int fails = 0;

    logic [17:0] plots[$];
    logic [17:0] exp_q[$];
    logic [31:0] exp_res;

    typedef struct {
        string       name;
        logic [39:0] ins;
        logic [31:0] res;
        int          npix;
        int          lat;
    } vec_t;
    vec_t tv[$];

    dp_draw_unit #(.SCREEN_W(SW), .SCREEN_H(SH), .WRITE_HOLD(WH)) dut (
        .clock          (clock),
        .reset          (reset),
        .start_dp       (start_dp),
        .instruction_dp (instruction_dp),
        .finished_dp    (finished_dp),
        .result_dp      (result_dp),
        .vga_x          (vga_x),
        .vga_y          (vga_y),
        .vga_colour     (vga_colour),
        .vga_plot       (vga_plot)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (vga_plot) plots.push_back({vga_x, vga_y, vga_colour});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    function automatic logic [39:0] mk_draw(input logic [7:0] x, input logic [6:0] y,
                                            input logic [2:0] c, input logic p);
        logic [39:0] w;
        w = '0;
        w[3:0] = OPCODE_DRAW; w[11:4] = x; w[18:12] = y; w[21:19] = c; w[22] = p;
        return w;
    endfunction

    function automatic logic [39:0] mk_fill(input logic [7:0] x0, input logic [6:0] y0,
                                            input logic [7:0] x1, input logic [6:0] y1,
                                            input logic [2:0] c);
        logic [39:0] w;
        w = '0;
        w[3:0] = OPCODE_FILL; w[11:4] = x0; w[18:12] = y0;
        w[26:19] = x1; w[33:27] = y1; w[36:34] = c;
        return w;
    endfunction

    function automatic logic [39:0] mk_op(input logic [3:0] op);
        logic [39:0] w;
        w = '0;
        w[3:0] = op;
        return w;
    endfunction

    task automatic add_vec(input string nm, input logic [39:0] ins, input logic [31:0] res,
                           input int npix, input int lat);
        vec_t v;
        v.name = nm; v.ins = ins; v.res = res; v.npix = npix; v.lat = lat;
        tv.push_back(v);
    endtask

    // Reference: the pixel list an instruction paints, in raster order, and its result.
    task automatic model(input logic [39:0] ins);
        int x0, y0, x1, y1, n;
        exp_q.delete();
        case (ins[3:0])
            OPCODE_DRAW: begin
                x0 = ins[11:4];
                y0 = ins[18:12];
                if (ins[22] && x0 < SW && y0 < SH) begin
                    exp_q.push_back({ins[11:4], ins[18:12], ins[21:19]});
                    exp_res = 1;
                end else begin
                    exp_res = 0;
                end
            end
            OPCODE_FILL: begin
                x0 = ins[11:4];  y0 = ins[18:12];
                x1 = ins[26:19]; y1 = ins[33:27];
                if (x1 > SW - 1) x1 = SW - 1;
                if (y1 > SH - 1) y1 = SH - 1;
                n = 0;
                for (int y = y0; y <= y1; y++)
                    for (int x = x0; x <= x1; x++) begin
                        exp_q.push_back({8'(x), 7'(y), ins[36:34]});
                        n++;
                    end
                exp_res = n;
            end
            default: exp_res = 32'hFFFF_FFFF;
        endcase
    endtask

    // Controller-style launch: strobe held 2 cycles, then wait for finished.
    task automatic run(input logic [39:0] ins, output int lat);
        plots.delete();
        instruction_dp = ins;
        start_dp = 1'b1;
        tick();
        tick();
        lat = 2;
        check("busy_two_cycles_after_start", {31'b0, finished_dp}, 32'd0);
        start_dp = 1'b0;
        while (!finished_dp && lat < LIMIT) begin
            tick();
            lat++;
        end
        check("finished_within_budget", {31'b0, finished_dp}, 32'd1);
    endtask

    task automatic verify(input string nm);
        int bad;
        bad = 0;
        check({nm, "_pixel_count"}, plots.size(), exp_q.size());
        if (plots.size() == exp_q.size())
            foreach (plots[i]) if (plots[i] !== exp_q[i]) bad++;
        check({nm, "_pixel_mismatches"}, bad, 0);
        check({nm, "_result"}, result_dp, exp_res);
    endtask

    initial begin
        int lat, n, bad_pix, bad_res, total;
        logic [39:0] ins;
        logic [3:0]  op;

        reset = 1'b1;
        start_dp = 1'b0;
        instruction_dp = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_finished", {31'b0, finished_dp}, 32'd1);
        check("reset_result", result_dp, 32'd0);
        check("reset_vga", {13'b0, vga_x, vga_y, vga_colour, vga_plot}, 32'd0);

        add_vec("draw_5_7",     mk_draw(8'd5, 7'd7, 3'b101, 1'b1),                 32'd1, 1, 3 + WH);
        add_vec("fill_2x3",     mk_fill(8'd2, 7'd3, 8'd4, 7'd4, 3'b010),           32'd6, 6, 3 + 6);
        add_vec("fill_clip",    mk_fill(8'd158, 7'd118, 8'd200, 7'd127, 3'b011),   32'd4, 4, 3 + 4);
        add_vec("fill_empty_x", mk_fill(8'd10, 7'd0, 8'd5, 7'd2, 3'b001),          32'd0, 0, 3);
        add_vec("fill_empty_y", mk_fill(8'd0, 7'd10, 8'd3, 7'd4, 3'b001),          32'd0, 0, 3);
        add_vec("fill_corner",  mk_fill(8'd159, 7'd119, 8'd159, 7'd119, 3'b111),   32'd1, 1, 3 + 1);
        add_vec("bad_opcode",   mk_op(4'hF),                                       32'hFFFF_FFFF, 0, 3);
        add_vec("draw_noplot",  mk_draw(8'd20, 7'd20, 3'b111, 1'b0),               32'd0, 0, 3);
        add_vec("draw_x160",    mk_draw(8'd160, 7'd5, 3'b111, 1'b1),               32'd0, 0, 3);
        add_vec("draw_y120",    mk_draw(8'd5, 7'd120, 3'b111, 1'b1),               32'd0, 0, 3);

        foreach (tv[i]) begin
            run(tv[i].ins, lat);
            model(tv[i].ins);
            verify(tv[i].name);
            check({tv[i].name, "_table_result"}, result_dp, tv[i].res);
            check({tv[i].name, "_table_pixels"}, plots.size(), tv[i].npix);
            check({tv[i].name, "_latency"}, lat, tv[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 9);
            if (n < 4) begin
                ins = mk_draw(8'($urandom_range(0, 170)), 7'($urandom_range(0, 127)),
                              3'($urandom), ($urandom_range(0, 3) != 0));
                ins[39:23] = 17'($urandom);
            end else if (n < 8) begin
                n = $urandom_range(0, 165);
                lat = $urandom_range(0, 124);
                ins = mk_fill(8'(n), 7'(lat), 8'(n + $urandom_range(0, 6) - 1),
                              7'(lat + $urandom_range(0, 5) - 1), 3'($urandom));
                ins[39:37] = 3'($urandom);
            end else begin
                op = 4'($urandom);
                if (op == OPCODE_DRAW || op == OPCODE_FILL) op = 4'hE;
                ins = 40'($urandom) << 4;
                ins[3:0] = op;
            end
            run(ins, lat);
            model(ins);
            verify("random");
        end

        // Strobe held high long after completion must execute only once.
        plots.delete();
        instruction_dp = mk_draw(8'd1, 7'd1, 3'b110, 1'b1);
        start_dp = 1'b1;
        repeat (10) tick();
        start_dp = 1'b0;
        repeat (3) tick();
        check("held_start_single_plot", plots.size(), 1);
        check("held_start_finished", {31'b0, finished_dp}, 32'd1);
        check("held_start_result", result_dp, 32'd1);

        // Background painter sweep.
        bad_pix = 0; bad_res = 0; total = 0;
        for (int y = 0; y < SH; y++)
            for (int x = 0; x < SW; x++) begin
                run(mk_draw(8'(x), 7'(y), COLOUR_BG, 1'b1), lat);
                total += plots.size();
                if (plots.size() != 1 || plots[0] !== {8'(x), 7'(y), COLOUR_BG}) bad_pix++;
                if (result_dp !== 32'd1) bad_res++;
            end
        check("painter_total_plots", total, SW * SH);
        check("painter_bad_pixels", bad_pix, 0);
        check("painter_bad_results", bad_res, 0);

        // Reset in the middle of a fill.
        plots.delete();
        instruction_dp = mk_fill(8'd0, 7'd0, 8'd9, 7'd9, 3'b110);
        start_dp = 1'b1;
        tick();
        tick();
        start_dp = 1'b0;
        n = 0;
        while (plots.size() < 3 && n < 50) begin
            tick();
            n++;
        end
        check("fill_pixels_before_reset", plots.size(), 3);
        reset = 1'b1;
        tick();
        check("midreset_vga_plot", {31'b0, vga_plot}, 32'd0);
        check("midreset_finished", {31'b0, finished_dp}, 32'd1);
        check("midreset_result", result_dp, 32'd0);
        reset = 1'b0;
        n = plots.size();
        repeat (5) tick();
        check("midreset_no_more_plots", plots.size(), n);
        run(mk_draw(8'd33, 7'd44, 3'b011, 1'b1), lat);
        model(mk_draw(8'd33, 7'd44, 3'b011, 1'b1));
        verify("after_reset_draw");
        check("after_reset_latency", lat, 3 + WH);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dp_draw_unit.md
Name: dp_draw_unit

Overview:
- Downstream datapath stage for the drawing controllers, such as the background painter.
- Accepts one instruction per start/finished handshake and decodes the opcode.
- Executes single-pixel DRAW and rectangle FILL by driving the VGA adapter write port, then returns a result word and raises finished.
- Sits between the controller mux and the VGA adapter.

Parameters:
- SCREEN_W, 160, pixel columns; FILL clips at SCREEN_W-1.
- SCREEN_H, 120, pixel rows; FILL clips at SCREEN_H-1.
- WRITE_HOLD, 1, cycles each pixel is held on the VGA port with vga_plot=1 (1..4).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start_dp  in  1  instruction strobe, held high 2 cycles by the controller.
- instruction_dp  in  INSTRUCTION_WIDTH(40)  instruction word; stable while start_dp is high.
- finished_dp  out  1  high when idle or done; low while executing.
- result_dp  out  RESULT_WIDTH(32)  result of the last instruction.
- vga_x  out  X_COORD_WIDTH(8)  pixel x.
- vga_y  out  Y_COORD_WIDTH(7)  pixel y.
- vga_colour  out  COLOUR_WIDTH(3)  pixel colour.
- vga_plot  out  1  write enable to the VGA adapter.

Behaviour:
- Instruction fields (LSB first): opcode[3:0].
  - DRAW: x[11:4], y[18:12], colour[21:19], plot[22].
  - FILL: x0[11:4], y0[18:12], x1[26:19], y1[33:27], colour[36:34].
- Reset (synchronous): state IDLE, finished_dp=1, result_dp=0, vga_* all 0. Reset mid-operation aborts immediately; no further pixels are written.
- IDLE, start_dp sampled 1:
  - Latch instruction_dp.
  - finished_dp=0 on the next cycle (no later), so a controller sampling finished two cycles after its start strobe sees 0.
  - Go to DECODE.
- DECODE:
  - OPCODE_DRAW:
    - plot=1: go to PLOT with cur=(x,y).
    - plot=0: go to DONE with result=0.
  - OPCODE_FILL: clip x1/y1 to screen, set cur=(x0,y0), count=0, go to PLOT.
    - If x0>x1 or y0>y1 after clipping, go to DONE with result=0.
  - Any other opcode: go to DONE with result=32'hFFFF_FFFF.
- PLOT:
  - vga_x/y/colour=cur and vga_plot=1 for exactly WRITE_HOLD cycles; count+=1.
  - DRAW then goes to DONE.
  - FILL raster order: x increments first. At x==x1, x wraps to x0 and y+=1. After (x1,y1), go to DONE.
  - vga_plot returns to 0 between pixels only when WRITE_HOLD>1; with WRITE_HOLD=1, consecutive pixels stream with vga_plot continuously high.
- DONE:
  - result_dp=count (DRAW gives 1); vga_plot=0; finished_dp=1; go to IDLE.
  - result_dp holds until the next instruction completes.
- start_dp while busy is ignored. The second cycle of the same strobe (DELAY cycle) must not relaunch: IDLE accepts start only on a 0→1 edge of start_dp.
- Arithmetic: coordinates are unsigned. Out-of-range DRAW coordinates (x≥SCREEN_W or y≥SCREEN_H) write nothing, finish with result=0.
- Latency: DRAW plot=1 takes start edge + 3 + WRITE_HOLD cycles until finished_dp=1.

Decomposition:
- constants.h gains OPCODE_FILL, INSTRUCTION_WIDTH=40, and the field bit positions. It reuses OPCODE_DRAW, coordinate/colour widths, RESULT_WIDTH and COLOUR_BG.
- One natural sub-module, dp_raster_walker: holds cur x/y and count, with init/step inputs and a last output. The top module keeps the FSM, decode and result.

Test Plan:
1. Reset, then DRAW x=5 y=7 colour=3'b101 plot=1 → exactly one vga_plot cycle (WRITE_HOLD=1) at (5,7,101); finished_dp low from start+1; result_dp=1.
2. FILL (2,3)-(4,4) colour=3'b010 → 6 pixels in order (2,3),(3,3),(4,3),(2,4),(3,4),(4,4); result_dp=6.
3. FILL (158,118)-(200,127) → clipped to (158..159,118..119): 4 pixels; result_dp=4. FILL x0=10 x1=5 → no plot; result_dp=0.
4. Opcode 4'hF → no vga_plot; result_dp=32'hFFFFFFFF. DRAW plot=0 and DRAW x=160 → result_dp=0, no plot.
5. Full background painter loop, 160×120 DRAWs with colour COLOUR_BG → 19200 plots, each pixel once, no relaunch on the DELAY cycle.
6. Assert reset mid-FILL after 3 pixels → vga_plot=0 next cycle, finished_dp=1, result_dp=0; next DRAW executes normally.
